// File: rtl/gem_clct_delta_calc_pkg.sv
// Shared constants for the GEM/CLCT bending-angle stage and the downstream tree encoder.
package gem_clct_delta_calc_pkg;
  localparam int GEM_NSLOTS = 8;
  localparam int PRI_W      = 10;
  localparam logic [PRI_W-1:0] PRI_NOMATCH = 10'h3FF;
  localparam int POS_W      = 10;
  localparam int KEY_W      = 8;
  localparam int AGE_W      = 3;
  localparam int NMATCH_W   = 4;

  // Unsigned |a - b| taken through an 11-bit signed difference, truncated to PRI_W.
  function automatic logic [PRI_W-1:0] abs_delta(input logic [POS_W-1:0] a,
                                                  input logic [POS_W-1:0] b);
    logic signed [POS_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    if (diff < 0) diff = -diff;
    return diff[PRI_W-1:0];
  endfunction
endpackage

// File: rtl/gem_clct_delta_calc_slot_hold.sv
// One GEM slot: latches a cluster position and keeps it matchable for WIN bx.
module gem_slot_hold
  import gem_clct_delta_calc_pkg::*;
#(
  parameter int WIN = 3
) (
  input  logic             clock,
  input  logic             global_reset,
  input  logic             gem_vpf,
  input  logic [POS_W-1:0] gem_pos,
  output logic             live,
  output logic [POS_W-1:0] pos
);
  logic [AGE_W-1:0] age;

  // Age stops advancing once the slot dies, so it never wraps.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      live <= 1'b0;
      age  <= '0;
      pos  <= '0;
    end else if (gem_vpf) begin
      live <= 1'b1;
      age  <= '0;
      pos  <= gem_pos;
    end else if (live) begin
      age <= age + 1'b1;
      if (age == AGE_W'(WIN - 1)) live <= 1'b0;
    end
  end
endmodule

// File: rtl/gem_clct_delta_calc.sv
// Per-slot saturated |CLCT - GEM| bending priorities, two-stage pipeline from clct_vpf.
module gem_clct_delta_calc
  import gem_clct_delta_calc_pkg::*;
#(
  parameter int               WIN       = 3,
  parameter logic [PRI_W-1:0] DELTA_MAX = 10'd63,
  parameter int               POS_SHIFT = 1
) (
  input  logic                            clock,
  input  logic                            global_reset,
  input  logic [GEM_NSLOTS-1:0]           gem_vpf,
  input  logic [GEM_NSLOTS*POS_W-1:0]     gem_pos,
  input  logic                            clct_vpf,
  input  logic [KEY_W-1:0]                clct_key_hs,
  output logic [PRI_W-1:0]                win_pri_0,
  output logic [PRI_W-1:0]                win_pri_1,
  output logic [PRI_W-1:0]                win_pri_2,
  output logic [PRI_W-1:0]                win_pri_3,
  output logic [PRI_W-1:0]                win_pri_4,
  output logic [PRI_W-1:0]                win_pri_5,
  output logic [PRI_W-1:0]                win_pri_6,
  output logic [PRI_W-1:0]                win_pri_7,
  output logic                            out_vpf,
  output logic [KEY_W-1:0]                out_key_hs,
  output logic [NMATCH_W-1:0]             out_nmatch
);
  localparam int STAGES = 2;

  logic [GEM_NSLOTS-1:0]             slot_live, snap_live, accept;
  logic [GEM_NSLOTS-1:0][POS_W-1:0]  slot_pos, snap_pos;
  logic [GEM_NSLOTS-1:0][PRI_W-1:0]  delta, pri_nxt, win_pri;
  logic [STAGES:1]                   vld_pipe;
  logic [KEY_W-1:0]                  s1_key;
  logic [POS_W-1:0]                  s1_pos, key_pos;
  logic [NMATCH_W-1:0]               nmatch_nxt;

  gem_slot_hold #(.WIN(WIN)) u_slot [GEM_NSLOTS-1:0] (
    .clock        (clock),
    .global_reset (global_reset),
    .gem_vpf      (gem_vpf),
    .gem_pos      (gem_pos),
    .live         (slot_live),
    .pos          (slot_pos)
  );

  assign key_pos = POS_W'(clct_key_hs) << POS_SHIFT;

  for (genvar i = 0; i < GEM_NSLOTS; i++) begin : g_lane
    assign delta[i]   = abs_delta(s1_pos, snap_pos[i]);
    assign accept[i]  = vld_pipe[1] && snap_live[i] && (delta[i] <= DELTA_MAX);
    assign pri_nxt[i] = accept[i] ? delta[i] : PRI_NOMATCH;
  end

  always_comb begin
    nmatch_nxt = '0;
    for (int i = 0; i < GEM_NSLOTS; i++) nmatch_nxt = nmatch_nxt + NMATCH_W'(accept[i]);
  end

  // Stage 1 snapshots the slots as they stood in the CLCT's own bx.
  always_ff @(posedge clock) begin
    if (global_reset) begin
      vld_pipe   <= '0;
      s1_key     <= '0;
      s1_pos     <= '0;
      snap_live  <= '0;
      snap_pos   <= '0;
      win_pri    <= {GEM_NSLOTS{PRI_NOMATCH}};
      out_key_hs <= '0;
      out_nmatch <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], clct_vpf};
      s1_key     <= clct_key_hs;
      s1_pos     <= key_pos;
      snap_live  <= slot_live;
      snap_pos   <= slot_pos;
      win_pri    <= pri_nxt;
      out_nmatch <= nmatch_nxt;
      if (vld_pipe[1]) out_key_hs <= s1_key;
    end
  end

  assign out_vpf   = vld_pipe[STAGES];
  assign win_pri_0 = win_pri[0];
  assign win_pri_1 = win_pri[1];
  assign win_pri_2 = win_pri[2];
  assign win_pri_3 = win_pri[3];
  assign win_pri_4 = win_pri[4];
  assign win_pri_5 = win_pri[5];
  assign win_pri_6 = win_pri[6];
  assign win_pri_7 = win_pri[7];
endmodule

// File: tb/tb_gem_clct_delta_calc.sv
// Randomized and directed check of gem_clct_delta_calc against a cycle-history reference model.
module tb_gem_clct_delta_calc;
  localparam int WIN = 3;
  localparam int DMAX = 63;

  logic        clock = 1'b0;
  logic        global_reset;
  logic [7:0]  gem_vpf;
  logic [79:0] gem_pos;
  logic        clct_vpf;
  logic [7:0]  clct_key_hs;
  logic [9:0]  win_pri_0, win_pri_1, win_pri_2, win_pri_3;
  logic [9:0]  win_pri_4, win_pri_5, win_pri_6, win_pri_7;
  logic        out_vpf;
  logic [7:0]  out_key_hs;
  logic [3:0]  out_nmatch;

  gem_clct_delta_calc dut (
    .clock(clock), .global_reset(global_reset), .gem_vpf(gem_vpf), .gem_pos(gem_pos),
    .clct_vpf(clct_vpf), .clct_key_hs(clct_key_hs),
    .win_pri_0(win_pri_0), .win_pri_1(win_pri_1), .win_pri_2(win_pri_2), .win_pri_3(win_pri_3),
    .win_pri_4(win_pri_4), .win_pri_5(win_pri_5), .win_pri_6(win_pri_6), .win_pri_7(win_pri_7),
    .out_vpf(out_vpf), .out_key_hs(out_key_hs), .out_nmatch(out_nmatch)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit vpf;
    int key;
    int pri[8];
    int nmatch;
  } exp_t;

  // Model: remember the bx of each slot's latest capture; a slot is usable by a
  // CLCT in bx c when it was captured in one of bx c-WIN .. c-1.
  int   cyc = 0;
  int   cap_cyc[8];
  int   cap_pos[8];
  int   last_key;
  exp_t pend, model_out;
  int   n_cmp = 0, n_bad = 0;
  bit   chk_en = 0;

  function automatic exp_t idle_out(input int key);
    exp_t e;
    e.vpf = 0; e.key = key; e.nmatch = 0;
    for (int i = 0; i < 8; i++) e.pri[i] = 'h3FF;
    return e;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) begin cap_cyc[i] = -100; cap_pos[i] = 0; end
    last_key  = 0;
    pend      = idle_out(0);
    model_out = idle_out(0);
  end

  always @(posedge clock) begin
    exp_t e;
    e = idle_out(0);
    e.vpf = clct_vpf;
    e.key = clct_key_hs;
    for (int i = 0; i < 8; i++) begin
      int d, age;
      age = cyc - cap_cyc[i];
      d = clct_key_hs * 2 - cap_pos[i];
      if (d < 0) d = -d;
      if (clct_vpf && age >= 1 && age <= WIN && d <= DMAX) begin
        e.pri[i] = d;
        e.nmatch++;
      end
    end
    if (global_reset) begin
      last_key  = 0;
      pend      = idle_out(0);
      model_out = idle_out(0);
      for (int i = 0; i < 8; i++) begin cap_cyc[i] = -100; cap_pos[i] = 0; end
    end else begin
      if (pend.vpf) begin
        last_key  = pend.key;
        model_out = pend;
      end else begin
        model_out = idle_out(last_key);
      end
      pend = e;
      for (int i = 0; i < 8; i++)
        if (gem_vpf[i]) begin cap_cyc[i] = cyc; cap_pos[i] = int'(gem_pos[10*i +: 10]); end
    end
    cyc++;
  end

  function automatic logic [79:0] act_pri();
    return {win_pri_7, win_pri_6, win_pri_5, win_pri_4, win_pri_3, win_pri_2, win_pri_1, win_pri_0};
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      logic [79:0] ep;
      for (int i = 0; i < 8; i++) ep[10*i +: 10] = 10'(model_out.pri[i]);
      n_cmp++;
      if (out_vpf !== model_out.vpf || out_key_hs !== 8'(model_out.key) ||
          out_nmatch !== 4'(model_out.nmatch) || act_pri() !== ep) begin
        n_bad++;
        $display("FAIL cycle %0d: got vpf=%0b key=%0d nm=%0d pri=%h, want vpf=%0b key=%0d nm=%0d pri=%h",
                 cyc, out_vpf, out_key_hs, out_nmatch, act_pri(),
                 model_out.vpf, model_out.key, model_out.nmatch, ep);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic setpos(input int s, input int p);
    gem_pos[10*s +: 10] = 10'(p);
  endtask

  task automatic drive(input logic [7:0] gv, input logic cv, input logic [7:0] key,
                       input logic rst = 1'b0);
    gem_vpf = gv; clct_vpf = cv; clct_key_hs = key; global_reset = rst;
    @(negedge clock);
  endtask

  initial begin
    global_reset = 1'b1; gem_vpf = '0; gem_pos = '0; clct_vpf = 1'b0; clct_key_hs = '0;
    repeat (3) @(negedge clock);
    chk_en = 1;
    chk("reset pri0", int'(win_pri_0), 'h3FF);
    chk("reset nmatch", int'(out_nmatch), 0);

    // basic match
    setpos(0, 100);
    drive(8'h01, 0, 0);
    drive(8'h00, 1, 52);
    drive(8'h00, 0, 0);
    chk("basic pri0", int'(win_pri_0), 4);
    chk("basic model pri0", model_out.pri[0], 4);
    chk("basic pri1", int'(win_pri_1), 'h3FF);
    chk("basic vpf", int'(out_vpf), 1);
    chk("basic nmatch", int'(out_nmatch), 1);
    chk("basic key", int'(out_key_hs), 52);

    // lifetime edge
    setpos(3, 50);
    drive(8'h08, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 25); drive(0, 0, 0);
    chk("life last bx pri3", int'(win_pri_3), 0);
    drive(8'h08, 0, 0); drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 25); drive(0, 0, 0);
    chk("life expired pri3", int'(win_pri_3), 'h3FF);
    chk("life expired model", model_out.pri[3], 'h3FF);

    // window edge, both signs
    setpos(1, 0);   drive(8'h02, 0, 0); drive(0, 1, 31); drive(0, 0, 0);
    chk("edge 62 pri1", int'(win_pri_1), 62);
    setpos(1, 0);   drive(8'h02, 0, 0); drive(0, 1, 32); drive(0, 0, 0);
    chk("edge 64 pri1", int'(win_pri_1), 'h3FF);
    setpos(1, 124); drive(8'h02, 0, 0); drive(0, 1, 31); drive(0, 0, 0);
    chk("edge -62 pri1", int'(win_pri_1), 62);
    setpos(1, 128); drive(8'h02, 0, 0); drive(0, 1, 32); drive(0, 0, 0);
    chk("edge -64 pri1", int'(win_pri_1), 'h3FF);

    // overwrite and same-cycle arrival
    setpos(5, 200); drive(8'h20, 0, 0);
    setpos(5, 300); drive(8'h20, 0, 0);
    drive(0, 1, 150); drive(0, 0, 0);
    chk("overwrite pri5", int'(win_pri_5), 0);
    setpos(6, 10); drive(8'h40, 1, 5); drive(0, 0, 0);
    chk("same-cycle pri6", int'(win_pri_6), 'h3FF);

    // back-to-back burst with reset in the middle
    for (int i = 0; i < 8; i++) setpos(i, 10 * i + 20);
    drive(8'hFF, 0, 0);
    drive(8'hFF, 1, 10);
    drive(8'h00, 1, 20);
    chk("b2b nmatch", int'(out_nmatch), 7);
    chk("b2b model nmatch", model_out.nmatch, 7);
    chk("b2b pri1", int'(win_pri_1), 10);
    chk("b2b pri7", int'(win_pri_7), 'h3FF);
    chk("b2b key", int'(out_key_hs), 10);
    drive(8'h00, 1, 30);
    chk("b2b2 pri2", int'(win_pri_2), 0);
    drive(8'hFF, 1, 40, 1'b1);
    chk("rst vpf", int'(out_vpf), 0);
    chk("rst key", int'(out_key_hs), 0);
    chk("rst nmatch", int'(out_nmatch), 0);
    chk("rst pri0", int'(win_pri_0), 'h3FF);
    drive(8'h00, 1, 10); drive(0, 0, 0);
    chk("post-rst vpf", int'(out_vpf), 1);
    chk("post-rst nmatch", int'(out_nmatch), 0);

    // random traffic
    repeat (3000) begin
      for (int i = 0; i < 8; i++)
        setpos(i, ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 1023))
                                                : int'($urandom_range(0, 460)));
      begin
        logic [7:0] gv;
        for (int i = 0; i < 8; i++) gv[i] = ($urandom_range(0, 5) == 0);
        drive(gv, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 223)),
              $urandom_range(0, 99) == 0);
      end
    end
    drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
